// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint: oversamples SPI_CLK/SPI_CS_n/MOSI on clk, receives a byte per
// slot on MOSI and returns one holding-register byte per slot on MISO (modes 0-3, bursts).
module spi_peripheral #(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  input  logic       SPI_CLK,
  input  logic       SPI_CS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       o_MISO_OE
);

  localparam logic CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam logic CPHA = (SPI_MODE & 1) != 0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       skip_q, skip_d;
  logic       done_q, done_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic       underrun_q, underrun_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic load;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_edge   = sclk_s ^ sclk_prev_q;
  assign lead_edge   = sclk_edge & (sclk_s != CPOL);
  assign trail_edge  = sclk_edge & (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    skip_d      = skip_q;
    done_d      = 1'b0;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    if (done_q) begin
      rx_byte_d = rx_shift_q;
      rx_dv_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
          // With CPHA=1 the first leading edge would otherwise shift past the MSB.
          skip_d  = CPHA;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              done_d = 1'b1;
              load   = 1'b1;
              // The next shift edge belongs to the old byte (CPHA=0) or precedes the new MSB.
              skip_d = 1'b1;
            end
          end
          if (shift_edge) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d  = 8'h00;
        underrun_d  = 1'b1;
      end
    end

    // A write coinciding with a load only lands when the holding register was already empty.
    if (i_TX_DV && !hold_full_q) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // CS resets to 0 so a reset released mid-transfer waits for a fresh CS fall.
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      skip_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_dv_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      skip_q      <= skip_d;
      done_q      <= done_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_TX_Ready    = ~hold_full_q;
  assign o_TX_Underrun = underrun_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_MISO_OE     = (state_q == ST_ACTIVE);
  assign MISO          = (state_q == ST_ACTIVE) & tx_shift_q[7];

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: one instance per SPI mode driven by a shared master, checked
// against a byte-level model of the holding register and slot loads.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk_base = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi0 = 1'b0;
  logic       mosi1 = 1'b0;
  logic       i_TX_DV = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;

  logic [3:0] tx_ready, underrun, rx_dv, miso, oe;
  logic [7:0] rx_byte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      spi_peripheral #(.SPI_MODE(gi), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_TX_Byte    (i_TX_Byte),
        .i_TX_DV      (i_TX_DV),
        .o_TX_Ready   (tx_ready[gi]),
        .o_TX_Underrun(underrun[gi]),
        .o_RX_Byte    (rx_byte[gi]),
        .o_RX_DV      (rx_dv[gi]),
        .SPI_CLK      (sclk_base ^ 1'(gi / 2)),
        .SPI_CS_n     (cs_n),
        .MOSI         ((gi % 2 == 1) ? mosi1 : mosi0),
        .MISO         (miso[gi]),
        .o_MISO_OE    (oe[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  // Pulse monitor: logs every received byte and counts underrun pulses per mode.
  logic [7:0] rx_log [4][64];
  int rx_cnt [4] = '{default: 0};
  int ur_cnt [4] = '{default: 0};

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m]) begin
        rx_log[m][rx_cnt[m] % 64] <= rx_byte[m];
        rx_cnt[m] <= rx_cnt[m] + 1;
      end
      if (underrun[m]) ur_cnt[m] <= ur_cnt[m] + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Byte-level reference: a one-entry holding register consumed by every slot load.
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  int         m_ur = 0;

  function automatic void model_write(input logic [7:0] b);
    if (!m_full) begin
      m_full = 1'b1;
      m_hold = b;
    end
  endfunction

  function automatic logic [7:0] model_load();
    if (m_full) begin
      m_full = 1'b0;
      return m_hold;
    end
    m_ur++;
    return 8'h00;
  endfunction

  logic [7:0] mb [8];
  bit         wr_en [8];
  logic [7:0] wr_val [8];
  bit         pend_wr = 1'b0;
  logic [7:0] pend_val = 8'h00;
  logic [7:0] got [4][8];
  int         ur_mid [4];

  task automatic half();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0 && pend_wr) begin
        i_TX_DV   = 1'b1;
        i_TX_Byte = pend_val;
        model_write(pend_val);
        pend_wr   = 1'b0;
      end else if (c == 1) begin
        i_TX_DV = 1'b0;
      end
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    i_TX_DV   = 1'b1;
    i_TX_Byte = b;
    model_write(b);
    @(negedge clk);
    i_TX_DV = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 4; m++) check("tx_ready_after_write", tx_ready[m], !m_full);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int m = 0; m < 4; m++) begin
      check({tag, "_tx_ready"}, tx_ready[m], 1);
      check({tag, "_miso_oe"}, oe[m], 0);
      check({tag, "_miso"}, miso[m], 0);
      check({tag, "_rx_dv"}, rx_dv[m], 0);
      check({tag, "_underrun"}, underrun[m], 0);
      check({tag, "_rx_byte"}, rx_byte[m], 0);
    end
  endtask

  // One chip-select transaction of n bytes, optionally cut short after abort_bits bits
  // or interrupted by a reset after rst_bits bits.
  task automatic xfer(input int n, input int abort_bits, input int rst_bits);
    int base_rx [4];
    int base_ur [4];
    logic [7:0] exp_slot [9];
    int nbits = 0;
    int done_bytes = 0;
    bit stop = 1'b0;
    m_ur = 0;
    for (int m = 0; m < 4; m++) begin
      base_rx[m] = rx_cnt[m];
      base_ur[m] = ur_cnt[m];
      ur_mid[m]  = -1;
    end
    cs_n = 1'b0;
    exp_slot[0] = model_load();
    half();
    for (int k = 0; k < n && !stop; k++) begin
      for (int i = 7; i >= 0 && !stop; i--) begin
        if (k == 0 && i == 0)
          for (int m = 0; m < 4; m++) ur_mid[m] = ur_cnt[m] - base_ur[m];
        if (wr_en[k] && i == 5) begin
          pend_wr  = 1'b1;
          pend_val = wr_val[k];
        end
        if (rst_bits > 0 && nbits == rst_bits) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          m_full = 1'b0;
          check_reset_outputs("midreset");
          stop = 1'b1;
        end else if (abort_bits > 0 && nbits == abort_bits) begin
          stop = 1'b1;
        end else begin
          mosi0 = mb[k][i];
          half();
          got[0][k][i] = miso[0];
          got[2][k][i] = miso[2];
          sclk_base = 1'b1;
          mosi1 = mb[k][i];
          half();
          got[1][k][i] = miso[1];
          got[3][k][i] = miso[3];
          sclk_base = 1'b0;
          nbits++;
        end
      end
      if (!stop) begin
        done_bytes++;
        exp_slot[k+1] = model_load();
      end
    end
    half();
    cs_n = 1'b1;
    half();
    half();
    for (int m = 0; m < 4; m++) begin
      check("rx_dv_count", rx_cnt[m] - base_rx[m], done_bytes);
      for (int k = 0; k < done_bytes; k++) begin
        check("rx_byte", rx_log[m][(base_rx[m] + k) % 64], mb[k]);
        check("miso_byte", got[m][k], exp_slot[k]);
      end
      check("underrun_count", ur_cnt[m] - base_ur[m], m_ur);
      check("tx_ready", tx_ready[m], !m_full);
      check("miso_oe_idle", oe[m], 0);
    end
    for (int k = 0; k < 8; k++) wr_en[k] = 1'b0;
    $display("xfer n=%0d done=%0d abort_bits=%0d rst_bits=%0d byte0=%02h slot0=%02h underruns=%0d",
             n, done_bytes, abort_bits, rst_bits, mb[0], exp_slot[0], m_ur);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      wr_en[k]  = 1'b0;
      wr_val[k] = 8'h00;
      mb[k]     = 8'h00;
    end
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single byte, then the complementary pattern, in all four modes at once.
    tx_write(8'h3C);
    mb[0] = 8'hA5;
    xfer(1, 0, 0);
    tx_write(8'h81);
    mb[0] = 8'h7E;
    xfer(1, 0, 0);

    // Two-byte burst with the second TX byte written after the first slot load.
    tx_write(8'h11);
    wr_en[0] = 1'b1;
    wr_val[0] = 8'h22;
    mb[0] = 8'hF0;
    mb[1] = 8'h0F;
    xfer(2, 0, 0);

    // Underrun: exactly one pulse for the byte's own slot.
    mb[0] = 8'h55;
    xfer(1, 0, 0);
    for (int m = 0; m < 4; m++) check("underrun_first_slot", ur_mid[m], 1);

    // Abort after 5 bits, then a clean byte.
    mb[0] = 8'($urandom);
    xfer(1, 5, 0);
    mb[0] = 8'hC3;
    xfer(1, 0, 0);

    // Reset at bit 4 with a byte waiting in the holding register.
    mb[0] = 8'($urandom);
    wr_en[0] = 1'b1;
    wr_val[0] = 8'($urandom);
    xfer(1, 0, 4);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      for (int k = 0; k < n; k++) begin
        mb[k]     = 8'($urandom);
        wr_en[k]  = ($urandom_range(0, 2) != 0);
        wr_val[k] = 8'($urandom);
      end
      xfer(n, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
